timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_timer_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Programmable interval timer with a prescaler, a compare match, periodic and
// one-shot modes, a level interrupt and a small register read/write port.
module timer_ctrl #(
  parameter logic [15:0] PRESC_RST = 16'd0,
  parameter logic [15:0] CMP_RST   = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  input  logic        irq_ack_i,
  output logic        irq_o,
  output logic        running_o
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 2;
  localparam int unsigned CW = 3;

  localparam logic [AW-1:0] ADDR_CTRL  = AW'(0);
  localparam logic [AW-1:0] ADDR_PRESC = AW'(1);
  localparam logic [AW-1:0] ADDR_CMP   = AW'(2);
  localparam logic [AW-1:0] ADDR_COUNT = AW'(3);

  // CTRL bit positions
  localparam int unsigned EN_BIT  = 0;
  localparam int unsigned PER_BIT = 1;
  localparam int unsigned IRQ_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  ctrl_q, ctrl_d;
  logic [DW-1:0]  presc_q, presc_d;
  logic [DW-1:0]  cmp_q, cmp_d;
  logic [DW-1:0]  count_q, count_d;
  logic [DW-1:0]  pcnt_q, pcnt_d;
  logic           pending_q, pending_d;
  logic           irq_q, irq_d;
  logic           running_q, running_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic wr_ctrl_c, wr_presc_c, wr_cmp_c, wr_count_c;
  logic stop_c, presc_hit_c, tick_c, match_c;

  // Decode writes and derive the prescaler tick / compare match for this cycle
  always_comb begin
    wr_ctrl_c   = wr_en_i && (addr_i == ADDR_CTRL);
    wr_presc_c  = wr_en_i && (addr_i == ADDR_PRESC);
    wr_cmp_c    = wr_en_i && (addr_i == ADDR_CMP);
    wr_count_c  = wr_en_i && (addr_i == ADDR_COUNT);
    stop_c      = wr_ctrl_c && !wdata_i[EN_BIT];
    presc_hit_c = (pcnt_q >= presc_q);
    // A COUNT load or a disable in the same cycle suppresses the tick
    tick_c      = (state_q == RUN) && presc_hit_c && !wr_count_c && !stop_c;
    match_c     = tick_c && (count_q == cmp_q);
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: register writes take priority over a one-shot completion
  always_comb begin
    state_d = state_q;
    if (stop_c) begin
      state_d = IDLE;
    end else if (wr_ctrl_c && (state_q != RUN)) begin
      state_d = RUN;
    end else if (match_c && !ctrl_q[PER_BIT]) begin
      state_d = DONE;
    end
  end

  // FSM outputs and datapath next values
  always_comb begin
    ctrl_d    = ctrl_q;
    presc_d   = presc_q;
    cmp_d     = cmp_q;
    count_d   = count_q;
    pcnt_d    = pcnt_q;
    pending_d = pending_q;
    rdata_d   = rdata_q;

    // Prescaler runs only in RUN; reaching PRESC wraps it and yields a tick
    if (state_q == RUN) begin
      pcnt_d = presc_hit_c ? '0 : pcnt_q + DW'(1);
    end

    if (irq_ack_i) begin
      pending_d = 1'b0;
    end

    // Tick: advance COUNT or handle the compare match (match beats ack)
    if (tick_c) begin
      if (match_c) begin
        pending_d = 1'b1;
        if (ctrl_q[PER_BIT]) begin
          count_d = '0;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
        end
      end else begin
        count_d = count_q + DW'(1);
      end
    end

    if (wr_ctrl_c) begin
      if (wdata_i[EN_BIT] && (state_q == RUN)) begin
        ctrl_d[IRQ_BIT:PER_BIT] = wdata_i[IRQ_BIT:PER_BIT];
      end else begin
        ctrl_d = wdata_i[CW-1:0];
        if (wdata_i[EN_BIT]) begin
          pcnt_d  = '0;
          count_d = '0;
        end
      end
    end

    if (wr_presc_c) begin
      presc_d = wdata_i;
    end

    if (wr_cmp_c) begin
      cmp_d = wdata_i;
    end

    if (wr_count_c) begin
      count_d = wdata_i;
      pcnt_d  = '0;
    end

    // Reads see the pre-write register values
    if (rd_en_i) begin
      case (addr_i)
        ADDR_CTRL:  rdata_d = {10'd0, pending_q, state_q, ctrl_q};
        ADDR_PRESC: rdata_d = presc_q;
        ADDR_CMP:   rdata_d = cmp_q;
        default:    rdata_d = count_q;
      endcase
    end

    running_d = (state_d == RUN);
    irq_d     = pending_d && ctrl_d[IRQ_BIT];
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      presc_q   <= PRESC_RST;
      cmp_q     <= CMP_RST;
      count_q   <= '0;
      pcnt_q    <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      running_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      cmp_q     <= cmp_d;
      count_q   <= count_d;
      pcnt_q    <= pcnt_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      running_q <= running_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign irq_o     = irq_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq_ack;
  logic        irq;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_PRESC = 2'd1;
  localparam logic [1:0] A_CMP   = 2'd2;
  localparam logic [1:0] A_COUNT = 2'd3;

  timer_ctrl #(
    .PRESC_RST (16'd0),
    .CMP_RST   (16'hFFFF)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_en),
    .rd_en_i   (rd_en),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .irq_ack_i (irq_ack),
    .irq_o     (irq),
    .running_o (running)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    rd_en = 1'b1;
    addr  = a;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = 2'd0;
    wdata   = 16'd0;
    irq_ack = 1'b0;

    // Reset values
    step(2);
    check("rst_irq", 16'(irq), 16'h0000);
    check("rst_running", 16'(running), 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    rst_n = 1'b1;
    step(1);
    rd(A_CTRL);  check("rst_ctrl", rdata, 16'h0000);
    rd(A_PRESC); check("rst_presc", rdata, 16'h0000);
    rd(A_CMP);   check("rst_cmp", rdata, 16'hFFFF);
    rd(A_COUNT); check("rst_count", rdata, 16'h0000);

    // Read and write of the same address return the old value; rdata holds
    rd_en = 1'b1; wr_en = 1'b1; addr = A_CMP; wdata = 16'h1234;
    step(1);
    rd_en = 1'b0; wr_en = 1'b0;
    check("rw_same_addr", rdata, 16'hFFFF);
    step(2);
    check("rdata_hold", rdata, 16'hFFFF);
    rd(A_CMP); check("cmp_written", rdata, 16'h1234);

    // Periodic: PRESC=3, COMPARE=2, CTRL=111 at E0
    wr(A_PRESC, 16'd3);
    wr(A_CMP, 16'd2);
    wr(A_CTRL, 16'h0007);                        // E0
    check("per_running", 16'(running), 16'h0001);
    step(4);                                     // E4
    rd(A_COUNT);                                 // E5 captures COUNT after E4
    check("per_count_e4", rdata, 16'd1);
    step(3);                                     // E8
    rd(A_COUNT);                                 // E9
    check("per_count_e8", rdata, 16'd2);
    step(2);                                     // E11
    check("per_irq_e11", 16'(irq), 16'h0000);
    step(1);                                     // E12
    check("per_irq_e12", 16'(irq), 16'h0001);
    rd(A_CTRL);                                  // E13
    check("per_ctrl", rdata, 16'h002F);
    rd(A_COUNT);                                 // E14
    check("per_count_wrap", rdata, 16'd0);
    ack();                                       // E15
    check("per_ack", 16'(irq), 16'h0000);
    step(8);                                     // E23
    check("per_irq_e23", 16'(irq), 16'h0000);
    step(1);                                     // E24
    check("per_irq_e24", 16'(irq), 16'h0001);

    // Ack on the same edge as the next match: set wins
    step(11);                                    // E35
    irq_ack = 1'b1;
    step(1);                                     // E36 match + ack
    irq_ack = 1'b0;
    check("ack_vs_match", 16'(irq), 16'h0001);
    ack();                                       // E37 ack alone
    check("ack_alone", 16'(irq), 16'h0000);
    wr(A_CTRL, 16'h0000);
    check("disable_running", 16'(running), 16'h0000);
    rd(A_CTRL); check("disable_ctrl", rdata, 16'h0000);

    // One-shot: same setup, CTRL=101
    wr(A_CTRL, 16'h0005);                        // F0
    check("os_running", 16'(running), 16'h0001);
    step(11);                                    // F11
    check("os_irq_f11", 16'(irq), 16'h0000);
    step(1);                                     // F12
    check("os_irq_f12", 16'(irq), 16'h0001);
    check("os_running_done", 16'(running), 16'h0000);
    rd(A_CTRL);  check("os_ctrl", rdata, 16'h0034);
    rd(A_COUNT); check("os_count", rdata, 16'd2);
    step(10);
    rd(A_COUNT); check("os_count_hold", rdata, 16'd2);
    check("os_still_stopped", 16'(running), 16'h0000);

    // PRESC=0, COMPARE=FFFF, COUNT=FFFE mid-run, periodic, irq disabled
    ack();
    wr(A_PRESC, 16'd0);
    wr(A_CMP, 16'hFFFF);
    wr(A_CTRL, 16'h0003);
    wr(A_COUNT, 16'hFFFE);                       // G0
    step(1);                                     // G1
    rd(A_COUNT);                                 // G2 (match)
    check("wrap_count_ffff", rdata, 16'hFFFF);
    check("wrap_irq_masked", 16'(irq), 16'h0000);
    rd(A_COUNT);                                 // G3
    check("wrap_count_zero", rdata, 16'd0);
    rd(A_CTRL);                                  // G4
    check("wrap_pending", rdata, 16'h002B);

    // COMPARE written below COUNT: reached only after COUNT wraps
    ack();
    wr(A_CTRL, 16'h0007);                        // mode update, no restart
    wr(A_COUNT, 16'd10);                         // H0
    wr(A_CMP, 16'd5);                            // H1 -> COUNT 11
    step(5);                                     // COUNT 16
    check("below_no_irq", 16'(irq), 16'h0000);
    rd(A_COUNT);                                 // H7
    check("below_count", rdata, 16'd16);
    wr(A_COUNT, 16'hFFFD);                       // J0
    step(2);                                     // J2
    rd(A_COUNT);                                 // J3
    check("below_count_ffff", rdata, 16'hFFFF);
    step(5);                                     // J8
    check("below_irq_j8", 16'(irq), 16'h0000);
    step(1);                                     // J9 match at 5
    check("below_irq_j9", 16'(irq), 16'h0001);
    rd(A_COUNT);
    check("below_count_zero", rdata, 16'd0);
    rd(A_CTRL);
    check("below_ctrl", rdata, 16'h002F);
    check("below_running", 16'(running), 16'h0001);

    // Reset pulse mid-run with irq high
    rst_n = 1'b0;
    #1;
    check("mid_rst_irq", 16'(irq), 16'h0000);
    check("mid_rst_running", 16'(running), 16'h0000);
    check("mid_rst_rdata", rdata, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
    check("post_rst_running", 16'(running), 16'h0000);
    rd(A_CTRL);  check("post_rst_ctrl", rdata, 16'h0000);
    rd(A_PRESC); check("post_rst_presc", rdata, 16'h0000);
    rd(A_CMP);   check("post_rst_cmp", rdata, 16'hFFFF);
    rd(A_COUNT); check("post_rst_count", rdata, 16'h0000);
    step(5);
    check("post_rst_idle", 16'(running), 16'h0000);
    check("post_rst_irq", 16'(irq), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
